// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// instruction ids of the memory ops, access size encodings, FSM states,
// the decoded-op payload and the decode/alignment helpers.
package dmem_access_ctrl_pkg;

   localparam int unsigned ID_W   = 6;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned CNT_W  = 8;

   // Instruction ids carried in the EX/MEM register (0 = bubble)
   localparam logic [ID_W-1:0] INSTR_LB  = 6'd3;
   localparam logic [ID_W-1:0] INSTR_LH  = 6'd4;
   localparam logic [ID_W-1:0] INSTR_LW  = 6'd5;
   localparam logic [ID_W-1:0] INSTR_LBU = 6'd6;
   localparam logic [ID_W-1:0] INSTR_LHU = 6'd7;
   localparam logic [ID_W-1:0] INSTR_SB  = 6'd8;
   localparam logic [ID_W-1:0] INSTR_SH  = 6'd9;
   localparam logic [ID_W-1:0] INSTR_SW  = 6'd10;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef struct packed {
      logic  valid;
      logic  is_store;
      logic  sign;
      size_e size;
   } mem_op_t;

   // Map an instruction id onto the memory-op fields; non-memory ids give valid=0
   function automatic mem_op_t decode_op(input logic [ID_W-1:0] id);
      mem_op_t op;
      op = '{valid: 1'b0, is_store: 1'b0, sign: 1'b0, size: SIZE_W};
      case (id)
         INSTR_LB:  op = '{valid: 1'b1, is_store: 1'b0, sign: 1'b1, size: SIZE_B};
         INSTR_LH:  op = '{valid: 1'b1, is_store: 1'b0, sign: 1'b1, size: SIZE_H};
         INSTR_LW:  op = '{valid: 1'b1, is_store: 1'b0, sign: 1'b0, size: SIZE_W};
         INSTR_LBU: op = '{valid: 1'b1, is_store: 1'b0, sign: 1'b0, size: SIZE_B};
         INSTR_LHU: op = '{valid: 1'b1, is_store: 1'b0, sign: 1'b0, size: SIZE_H};
         INSTR_SB:  op = '{valid: 1'b1, is_store: 1'b1, sign: 1'b0, size: SIZE_B};
         INSTR_SH:  op = '{valid: 1'b1, is_store: 1'b1, sign: 1'b0, size: SIZE_H};
         INSTR_SW:  op = '{valid: 1'b1, is_store: 1'b1, sign: 1'b0, size: SIZE_W};
         default:   op = '{valid: 1'b0, is_store: 1'b0, sign: 1'b0, size: SIZE_W};
      endcase
      return op;
   endfunction

   // Half needs addr[0]=0, word needs addr[1:0]=0
   function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
      return ((size == SIZE_H) && lo[0]) || ((size == SIZE_W) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data-memory bus (purely combinational).
// Store side: replicates byte/half store data across lanes and builds wstrb
//    (i_st_*: size, store flag, addr[1:0], data from the current decode).
// Load side: picks the addressed byte/half of the read word and sign- or
//    zero-extends it (i_ld_*: latched size, sign, addr[1:0]; i_rdata).
module dmem_lane_align
   import dmem_access_ctrl_pkg::*;
(
   input  size_e             i_st_size,
   input  logic              i_st_is_store,
   input  logic [1:0]        i_st_addr_lo,
   input  logic [DATA_W-1:0] i_store_data,
   output logic [DATA_W-1:0] o_wdata,
   output logic [STRB_W-1:0] o_wstrb,
   input  size_e             i_ld_size,
   input  logic              i_ld_sign,
   input  logic [1:0]        i_ld_addr_lo,
   input  logic [DATA_W-1:0] i_rdata,
   output logic [DATA_W-1:0] o_ld_data
);

   logic [DATA_W-1:0] w_shift;

   // Store lane replication and byte enables
   always_comb begin
      o_wdata = i_store_data;
      o_wstrb = 4'hF;
      case (i_st_size)
         SIZE_B: begin
            o_wdata = {4{i_store_data[7:0]}};
            o_wstrb = 4'b0001 << i_st_addr_lo;
         end
         SIZE_H: begin
            o_wdata = {2{i_store_data[15:0]}};
            o_wstrb = 4'b0011 << i_st_addr_lo;
         end
         default: begin
            o_wdata = i_store_data;
            o_wstrb = 4'hF;
         end
      endcase
      if (!i_st_is_store) begin
         o_wstrb = '0;
      end
   end

   // Move the addressed byte/half down to bit 0 before extension
   assign w_shift = i_rdata >> {i_ld_addr_lo, 3'b000};

   always_comb begin
      o_ld_data = w_shift;
      case (i_ld_size)
         SIZE_B:  o_ld_data = {{24{i_ld_sign & w_shift[7]}}, w_shift[7:0]};
         SIZE_H:  o_ld_data = {{16{i_ld_sign & w_shift[15]}}, w_shift[15:0]};
         default: o_ld_data = w_shift;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller. Decodes the op held in EX/MEM,
// runs one req/gnt/rvalid transaction, stalls the pipeline while it is
// outstanding and returns extended load data.
// Ports: clk, rst (async, active-high); i_instr_id/i_mem_addr/i_store_data
//    from EX/MEM; o_stall to EX/MEM and upstream; o_dmem_* / i_dmem_* bus;
//    o_load_data/o_load_valid to MEM/WB; o_misaligned_exc, o_bus_err pulses.
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ID_W-1:0]   i_instr_id,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [DATA_W-1:0] i_store_data,
   output logic              o_stall,
   output logic              o_dmem_req,
   output logic              o_dmem_we,
   output logic [ADDR_W-1:0] o_dmem_addr,
   output logic [DATA_W-1:0] o_dmem_wdata,
   output logic [STRB_W-1:0] o_dmem_wstrb,
   input  logic              i_dmem_gnt,
   input  logic              i_dmem_rvalid,
   input  logic [DATA_W-1:0] i_dmem_rdata,
   output logic [DATA_W-1:0] o_load_data,
   output logic              o_load_valid,
   output logic              o_misaligned_exc,
   output logic              o_bus_err
);

   state_e            r_state;
   state_e            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_dmem_addr;
   logic [1:0]        r_addr_lo;
   logic              r_we;
   logic              r_sign;
   size_e             r_size;
   logic [DATA_W-1:0] r_wdata;
   logic [STRB_W-1:0] r_wstrb;
   logic [DATA_W-1:0] r_load_data;
   logic              r_load_valid;

   mem_op_t           w_op;
   logic              w_misaligned;
   logic              w_aligned_op;
   logic              w_latch;
   logic              w_cnt_clr;
   logic              w_cnt_inc;
   logic              w_rd_capture;
   logic              w_timeout;
   logic              w_stall;
   logic              w_mis_exc;
   logic              w_at_limit;
   logic [DATA_W-1:0] w_lane_wdata;
   logic [STRB_W-1:0] w_lane_wstrb;
   logic [DATA_W-1:0] w_ld_ext;

   assign w_op         = decode_op(i_instr_id);
   assign w_misaligned = w_op.valid && is_misaligned(w_op.size, i_mem_addr[1:0]);
   assign w_aligned_op = w_op.valid && !w_misaligned;
   assign w_at_limit   = (r_cnt == CNT_W'(TIMEOUT_CYCLES));

   dmem_lane_align u_lane (
      .i_st_size     (w_op.size),
      .i_st_is_store (w_op.is_store),
      .i_st_addr_lo  (i_mem_addr[1:0]),
      .i_store_data  (i_store_data),
      .o_wdata       (w_lane_wdata),
      .o_wstrb       (w_lane_wstrb),
      .i_ld_size     (r_size),
      .i_ld_sign     (r_sign),
      .i_ld_addr_lo  (r_addr_lo),
      .i_rdata       (i_dmem_rdata),
      .o_ld_data     (w_ld_ext)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and per-cycle controls; grant/rvalid win over a same-cycle timeout
   always_comb begin
      w_next       = r_state;
      w_latch      = 1'b0;
      w_cnt_clr    = 1'b0;
      w_cnt_inc    = 1'b0;
      w_rd_capture = 1'b0;
      w_timeout    = 1'b0;
      w_stall      = 1'b0;
      w_mis_exc    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_aligned_op) begin
               w_stall   = 1'b1;
               w_latch   = 1'b1;
               w_cnt_clr = 1'b1;
               w_next    = ST_REQ;
            end else if (w_op.valid) begin
               w_mis_exc = 1'b1;
            end
         end
         ST_REQ: begin
            w_stall = 1'b1;
            if (i_dmem_gnt) begin
               w_next = r_we ? ST_DONE : ST_WAIT;
            end else if (w_at_limit) begin
               w_timeout = 1'b1;
               w_next    = ST_DONE;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         ST_WAIT: begin
            w_stall = 1'b1;
            if (i_dmem_rvalid) begin
               w_rd_capture = 1'b1;
               w_next       = ST_DONE;
            end else if (w_at_limit) begin
               w_timeout = 1'b1;
               w_next    = ST_DONE;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Latched access fields, timeout counter and load result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= '0;
         r_dmem_addr  <= '0;
         r_addr_lo    <= '0;
         r_we         <= 1'b0;
         r_sign       <= 1'b0;
         r_size       <= SIZE_W;
         r_wdata      <= '0;
         r_wstrb      <= '0;
         r_load_data  <= '0;
         r_load_valid <= 1'b0;
      end else begin
         r_load_valid <= w_rd_capture;
         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_latch) begin
            r_dmem_addr <= {i_mem_addr[ADDR_W-1:2], 2'b00};
            r_addr_lo   <= i_mem_addr[1:0];
            r_we        <= w_op.is_store;
            r_sign      <= w_op.sign;
            r_size      <= w_op.size;
            r_wdata     <= w_lane_wdata;
            r_wstrb     <= w_lane_wstrb;
         end
         if (w_rd_capture) begin
            r_load_data <= w_ld_ext;
         end else if (w_timeout) begin
            r_load_data <= '0;
         end
      end
   end

   // Pipeline-facing pulses are forced low while reset is held
   assign o_stall          = w_stall && !rst;
   assign o_misaligned_exc = w_mis_exc && !rst;
   assign o_bus_err        = w_timeout;
   assign o_dmem_req       = (r_state == ST_REQ);
   assign o_dmem_we        = r_we;
   assign o_dmem_addr      = r_dmem_addr;
   assign o_dmem_wdata     = r_wdata;
   assign o_dmem_wstrb     = r_wstrb;
   assign o_load_data      = r_load_data;
   assign o_load_valid     = r_load_valid;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a bus responder with programmable
// grant delay, expected bus requests and load results queued when each op
// is driven and popped when the DUT produces them.
module tb_dmem_access_ctrl;
   import dmem_access_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  instr_id;
   logic [31:0] mem_addr;
   logic [31:0] store_data;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic [31:0] load_data;
   logic        load_valid;
   logic        misaligned_exc;
   logic        bus_err;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } bus_req_t;

   bus_req_t    req_q[$];
   logic [31:0] ld_q[$];
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .i_instr_id       (instr_id),
      .i_mem_addr       (mem_addr),
      .i_store_data     (store_data),
      .o_stall          (stall),
      .o_dmem_req       (dmem_req),
      .o_dmem_we        (dmem_we),
      .o_dmem_addr      (dmem_addr),
      .o_dmem_wdata     (dmem_wdata),
      .o_dmem_wstrb     (dmem_wstrb),
      .i_dmem_gnt       (dmem_gnt),
      .i_dmem_rvalid    (dmem_rvalid),
      .i_dmem_rdata     (dmem_rdata),
      .o_load_data      (load_data),
      .o_load_valid     (load_valid),
      .o_misaligned_exc (misaligned_exc),
      .o_bus_err        (bus_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stall"}, 32'(stall), 0);
      chk({tag, "_req"}, 32'(dmem_req), 0);
      chk({tag, "_we"}, 32'(dmem_we), 0);
      chk({tag, "_addr"}, dmem_addr, 0);
      chk({tag, "_wdata"}, dmem_wdata, 0);
      chk({tag, "_wstrb"}, 32'(dmem_wstrb), 0);
      chk({tag, "_ldata"}, load_data, 0);
      chk({tag, "_lvalid"}, 32'(load_valid), 0);
      chk({tag, "_mis"}, 32'(misaligned_exc), 0);
      chk({tag, "_berr"}, 32'(bus_err), 0);
   endtask

   // Hold one op in EX/MEM until stall drops; gnt_delay<0 means never grant.
   // Entered and left at posedge+1.
   task automatic run_op(input string tag, input logic [5:0] id, input logic [31:0] addr,
                         input logic [31:0] sdata, input int gnt_delay, input logic [31:0] rd,
                         input logic push_req, input bus_req_t exp_req,
                         input logic push_ld, input logic [31:0] exp_ld,
                         input int exp_stall, input int exp_req_cyc, input int exp_lv,
                         input int exp_mis, input int exp_berr);
      int       n_stall = 0, n_req = 0, n_lv = 0, n_mis = 0, n_berr = 0, n_gnt = 0;
      int       req_seen = 0;
      int       cyc = 0;
      logic     rv_pend = 1'b0;
      logic     saw_berr = 1'b0;
      logic     done = 1'b0;
      bus_req_t e;
      logic [31:0] el;
      instr_id   = id;
      mem_addr   = addr;
      store_data = sdata;
      if (push_req) req_q.push_back(exp_req);
      if (push_ld)  ld_q.push_back(exp_ld);
      while (!done && cyc < 600) begin
         dmem_gnt    = 1'b0;
         dmem_rvalid = 1'b0;
         dmem_rdata  = 32'h0;
         if (rv_pend) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rd;
            rv_pend     = 1'b0;
         end
         if (dmem_req) begin
            if (gnt_delay >= 0 && req_seen == gnt_delay) begin
               dmem_gnt = 1'b1;
               rv_pend  = !exp_req.we;
            end
            req_seen++;
         end
         @(negedge clk);
         if (stall)          n_stall++;
         if (dmem_req)       n_req++;
         if (load_valid)     n_lv++;
         if (misaligned_exc) n_mis++;
         if (bus_err)        n_berr++;
         if (dmem_req && dmem_gnt) begin
            n_gnt++;
            if (req_q.size() == 0) begin
               chk({tag, "_unexpected_req"}, 1, 0);
            end else begin
               e = req_q.pop_front();
               chk({tag, "_we"}, 32'(dmem_we), 32'(e.we));
               chk({tag, "_addr"}, dmem_addr, e.addr);
               chk({tag, "_wstrb"}, 32'(dmem_wstrb), 32'(e.wstrb));
               if (e.we) chk({tag, "_wdata"}, dmem_wdata, e.wdata);
            end
         end
         if (load_valid) begin
            if (ld_q.size() == 0) begin
               chk({tag, "_unexpected_load"}, 1, 0);
            end else begin
               el = ld_q.pop_front();
               chk({tag, "_ldata"}, load_data, el);
            end
         end
         if (saw_berr && !stall) chk({tag, "_ldata_after_err"}, load_data, 0);
         if (bus_err) saw_berr = 1'b1;
         if (!stall) done = 1'b1;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!done) chk({tag, "_hang"}, 0, 1);
      instr_id    = 6'd0;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      chk({tag, "_stall_cycles"}, 32'(n_stall), 32'(exp_stall));
      chk({tag, "_req_cycles"}, 32'(n_req), 32'(exp_req_cyc));
      chk({tag, "_gnt_count"}, 32'(n_gnt), push_req ? 32'd1 : 32'd0);
      chk({tag, "_lvalid_pulses"}, 32'(n_lv), 32'(exp_lv));
      chk({tag, "_mis_pulses"}, 32'(n_mis), 32'(exp_mis));
      chk({tag, "_berr_pulses"}, 32'(n_berr), 32'(exp_berr));
   endtask

   initial begin
      rst         = 1'b1;
      instr_id    = INSTR_SW;
      mem_addr    = 32'h0000_0100;
      store_data  = 32'h1111_2222;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h0;

      // Reset state, with an aligned op already presented
      #2;
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      rst      = 1'b0;
      instr_id = 6'd0;
      @(posedge clk);
      #1;

      // 1: SW, grant on first REQ cycle
      run_op("sw", INSTR_SW, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0,
             1'b1, '{we: 1'b1, addr: 32'h0000_0100, wdata: 32'hDEAD_BEEF, wstrb: 4'hF},
             1'b0, 32'h0, 2, 1, 0, 0, 0);

      // 2: LB from the top byte, sign-extended
      run_op("lb", INSTR_LB, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234,
             1'b1, '{we: 1'b0, addr: 32'h0000_0100, wdata: 32'h0, wstrb: 4'h0},
             1'b1, 32'hFFFF_FF80, 3, 1, 1, 0, 0);

      // 3: LHU from the upper half with a 5-cycle grant delay
      run_op("lhu", INSTR_LHU, 32'h0000_0102, 32'h0, 5, 32'hBEEF_0000,
             1'b1, '{we: 1'b0, addr: 32'h0000_0100, wdata: 32'h0, wstrb: 4'h0},
             1'b1, 32'h0000_BEEF, 8, 6, 1, 0, 0);

      // 4: misaligned LW -> exception pulse, no bus cycle, no stall
      run_op("lw_mis", INSTR_LW, 32'h0000_0101, 32'h0, 0, 32'h0,
             1'b0, '{we: 1'b0, addr: 32'h0, wdata: 32'h0, wstrb: 4'h0},
             1'b0, 32'h0, 0, 0, 0, 1, 0);

      // 6: reset while waiting for read data
      instr_id = INSTR_LW;
      mem_addr = 32'h0000_0400;
      @(negedge clk);
      chk("rst_idle_stall", 32'(stall), 1);
      @(posedge clk);
      #1;
      dmem_gnt = 1'b1;
      @(negedge clk);
      chk("rst_req", 32'(dmem_req), 1);
      @(posedge clk);
      #1;
      dmem_gnt = 1'b0;
      @(negedge clk);
      chk("rst_wait_stall", 32'(stall), 1);
      chk("rst_wait_noreq", 32'(dmem_req), 0);
      #1;
      rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_op("lw_after_rst", INSTR_LW, 32'h0000_0400, 32'h0, 0, 32'h1357_9BDF,
             1'b1, '{we: 1'b0, addr: 32'h0000_0400, wdata: 32'h0, wstrb: 4'h0},
             1'b1, 32'h1357_9BDF, 3, 1, 1, 0, 0);

      // 5: LW never granted -> bus_err on the 256th REQ cycle
      run_op("lw_timeout", INSTR_LW, 32'h0000_0200, 32'h0, -1, 32'h0,
             1'b0, '{we: 1'b0, addr: 32'h0, wdata: 32'h0, wstrb: 4'h0},
             1'b0, 32'h0, 257, 256, 0, 0, 1);

      // 7: back-to-back SB then LW
      run_op("sb", INSTR_SB, 32'h0000_0202, 32'h1234_56A5, 0, 32'h0,
             1'b1, '{we: 1'b1, addr: 32'h0000_0200, wdata: 32'hA5A5_A5A5, wstrb: 4'b0100},
             1'b0, 32'h0, 2, 1, 0, 0, 0);
      run_op("lw_b2b", INSTR_LW, 32'h0000_0300, 32'h0, 0, 32'hCAFE_F00D,
             1'b1, '{we: 1'b0, addr: 32'h0000_0300, wdata: 32'h0, wstrb: 4'h0},
             1'b1, 32'hCAFE_F00D, 3, 1, 1, 0, 0);

      chk("req_q_drained", 32'(req_q.size()), 0);
      chk("ld_q_drained", 32'(ld_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
